// File: rtl/rtc_bus_cycle.sv
// rtl/rtc_bus_cycle.sv - bus-cycle generator for the RTC chip's multiplexed address/data bus
//
// Expands one read/write request into an address phase, an idle gap and a
// data phase, each with programmable setup/strobe/hold widths. Owns the
// tri-state enable of dato and returns captured read data with a done pulse.
//
// Optional feature macro: RTC_BUS_WRITE_VERIFY_EN
//   defined   - every write is followed by a gap and a read-back of the same
//               address; err flags a read-back mismatch with done.
//   undefined - no read-back, err is tied low.
//
// Ports:
//   clk    - rising-edge clock
//   reset  - synchronous active-low reset
//   start  - request strobe, sampled only when idle
//   rw     - 1 = read, 0 = write (sampled with start)
//   addr   - RTC register address (sampled with start)
//   wdata  - write data (sampled with start)
//   busy   - transaction in progress, including the done cycle
//   done   - one-cycle completion pulse
//   rdata  - last captured read data
//   err    - write-verify mismatch, valid with done
//   dato   - multiplexed address/data bus
//   a_d    - low = address phase, high = data phase
//   cs     - active-low chip select
//   rd     - active-low read strobe
//   wr     - active-low write strobe
module rtc_bus_cycle #(
  parameter int T_SETUP  = 2,
  parameter int T_STROBE = 5,
  parameter int T_HOLD   = 2,
  parameter int T_GAP    = 5
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       rw,
  input  logic [7:0] addr,
  input  logic [7:0] wdata,
  output logic       busy,
  output logic       done,
  output logic [7:0] rdata,
  output logic       err,
  inout  wire  [7:0] dato,
  output logic       a_d,
  output logic       cs,
  output logic       rd,
  output logic       wr
);

  localparam int CW = 8;

  localparam logic [3:0] S_IDLE     = 4'd0;
  localparam logic [3:0] S_A_SETUP  = 4'd1;
  localparam logic [3:0] S_A_STROBE = 4'd2;
  localparam logic [3:0] S_A_HOLD   = 4'd3;
  localparam logic [3:0] S_GAP      = 4'd4;
  localparam logic [3:0] S_D_SETUP  = 4'd5;
  localparam logic [3:0] S_D_STROBE = 4'd6;
  localparam logic [3:0] S_D_HOLD   = 4'd7;
  localparam logic [3:0] S_DONE     = 4'd8;
  localparam logic [3:0] S_V_GAP    = 4'd9;

  logic [3:0]    state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic          adv;
  logic          op_rd, op_rd_n;
  logic [7:0]    addr_q, addr_n;
  logic [7:0]    wdata_q, wdata_n;
  logic [7:0]    dato_q, dato_n;
  logic          dato_oe, oe_n;
  logic          in_a, in_d;

`ifdef RTC_BUS_WRITE_VERIFY_EN
  logic verify, verify_n;
  logic err_q, err_n;
`endif

  assign adv  = (cnt == CW'(1));
  assign dato = dato_oe ? dato_q : 8'bz;

  // Next-state and phase counter: each state loads its own length on entry
  // and leaves when the counter has run down to 1.
  always_comb begin
    state_n = state;
    cnt_n   = cnt - CW'(1);
    op_rd_n = op_rd;
    addr_n  = addr_q;
    wdata_n = wdata_q;
`ifdef RTC_BUS_WRITE_VERIFY_EN
    verify_n = verify;
`endif
    case (state)
      S_IDLE: begin
        cnt_n = '0;
        if (start) begin
          state_n = S_A_SETUP;
          cnt_n   = CW'(T_SETUP);
          op_rd_n = rw;
          addr_n  = addr;
          wdata_n = wdata;
`ifdef RTC_BUS_WRITE_VERIFY_EN
          verify_n = 1'b0;
`endif
        end
      end
      S_A_SETUP:  if (adv) begin state_n = S_A_STROBE; cnt_n = CW'(T_STROBE); end
      S_A_STROBE: if (adv) begin state_n = S_A_HOLD;   cnt_n = CW'(T_HOLD);   end
      S_A_HOLD:   if (adv) begin state_n = S_GAP;      cnt_n = CW'(T_GAP);    end
      S_GAP:      if (adv) begin state_n = S_D_SETUP;  cnt_n = CW'(T_SETUP);  end
      S_D_SETUP:  if (adv) begin state_n = S_D_STROBE; cnt_n = CW'(T_STROBE); end
      S_D_STROBE: if (adv) begin state_n = S_D_HOLD;   cnt_n = CW'(T_HOLD);   end
      S_D_HOLD: begin
        if (adv) begin
          state_n = S_DONE;
          cnt_n   = '0;
`ifdef RTC_BUS_WRITE_VERIFY_EN
          // A first-pass write turns into a read of the same address.
          if (!op_rd) begin
            state_n  = S_V_GAP;
            cnt_n    = CW'(T_GAP);
            op_rd_n  = 1'b1;
            verify_n = 1'b1;
          end
`endif
        end
      end
      S_DONE: begin
        state_n = S_IDLE;
        cnt_n   = '0;
      end
`ifdef RTC_BUS_WRITE_VERIFY_EN
      S_V_GAP:    if (adv) begin state_n = S_A_SETUP;  cnt_n = CW'(T_SETUP);  end
`endif
      default: begin
        state_n = S_IDLE;
        cnt_n   = '0;
      end
    endcase
  end

  // Pin values are decoded from the next state so every pin comes from a flop.
  always_comb begin
    in_a   = (state_n == S_A_SETUP) || (state_n == S_A_STROBE) || (state_n == S_A_HOLD);
    in_d   = (state_n == S_D_SETUP) || (state_n == S_D_STROBE) || (state_n == S_D_HOLD);
    oe_n   = in_a || (in_d && !op_rd_n);
    // Hold the last driven value when released; only the enable matters then.
    dato_n = in_a ? addr_n : ((in_d && !op_rd_n) ? wdata_n : dato_q);
`ifdef RTC_BUS_WRITE_VERIFY_EN
    err_n  = (state_n == S_DONE) && verify && (rdata != wdata_q);
`endif
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state   <= S_IDLE;
      cnt     <= '0;
      op_rd   <= 1'b0;
      addr_q  <= 8'h00;
      wdata_q <= 8'h00;
      dato_q  <= 8'h00;
      dato_oe <= 1'b0;
      a_d     <= 1'b1;
      cs      <= 1'b1;
      rd      <= 1'b1;
      wr      <= 1'b1;
      busy    <= 1'b0;
      done    <= 1'b0;
      rdata   <= 8'h00;
`ifdef RTC_BUS_WRITE_VERIFY_EN
      verify  <= 1'b0;
      err_q   <= 1'b0;
`endif
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      op_rd   <= op_rd_n;
      addr_q  <= addr_n;
      wdata_q <= wdata_n;
      dato_q  <= dato_n;
      dato_oe <= oe_n;
      a_d     <= !in_a;
      cs      <= !(in_a || in_d);
      wr      <= !((state_n == S_A_STROBE) || ((state_n == S_D_STROBE) && !op_rd_n));
      rd      <= !((state_n == S_D_STROBE) && op_rd_n);
      busy    <= (state_n != S_IDLE);
      done    <= (state_n == S_DONE);
      // Capture on the edge that ends the last read-strobe cycle, rd still low.
      if ((state == S_D_STROBE) && adv && op_rd)
        rdata <= dato;
`ifdef RTC_BUS_WRITE_VERIFY_EN
      verify  <= verify_n;
      err_q   <= err_n;
`endif
    end
  end

`ifdef RTC_BUS_WRITE_VERIFY_EN
  assign err = err_q;
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_rtc_bus_cycle.sv
// tb/tb_rtc_bus_cycle.sv - directed self-checking bench for rtc_bus_cycle
module tb_rtc_bus_cycle;

  localparam int N = 23;
`ifdef RTC_BUS_WRITE_VERIFY_EN
  localparam int WLAT = 51;
  localparam bit VFY  = 1'b1;
`else
  localparam int WLAT = 23;
  localparam bit VFY  = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       start = 1'b0;
  logic       rw = 1'b0;
  logic [7:0] addr = 8'h00;
  logic [7:0] wdata = 8'h00;
  logic       busy, done, err, a_d, cs, rd, wr;
  logic [7:0] rdata;
  wire  [7:0] dato;

  // RTC chip model: returns rdval while rd is low, otherwise parks the bus at
  // 8'h00 whenever the DUT should not be driving, so a stray DUT drive shows up.
  logic [7:0] rdval = 8'h00;
  logic       wr_txn = 1'b0;
  assign dato = (a_d && (!rd || cs || !wr_txn)) ? (!rd ? rdval : 8'h00) : 8'bz;

  rtc_bus_cycle dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .rw    (rw),
    .addr  (addr),
    .wdata (wdata),
    .busy  (busy),
    .done  (done),
    .rdata (rdata),
    .err   (err),
    .dato  (dato),
    .a_d   (a_d),
    .cs    (cs),
    .rd    (rd),
    .wr    (wr)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic run_txn(input string tag, input logic r, input logic [7:0] a, input logic [7:0] d,
                         input logic [7:0] rv, input logic pulses, input int lat,
                         output logic err_s, output logic [7:0] rdata_s);
    int aw_cnt = 0, aw_first = -1, dw_cnt = 0, dw_first = -1;
    int rd_cnt = 0, rd_first = -1, done_cnt = 0, done_k = -1;
    int bad_a = 0, bad_d = 0, bad_r = 0, bad_z = 0, busy_bad = 0;
    logic vfy;
    vfy     = !r && VFY;
    err_s   = 1'b0;
    rdata_s = 8'h00;
    @(negedge clk);
    rw = r; addr = a; wdata = d; rdval = rv; wr_txn = !r; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    for (int k = 0; k <= lat + 3; k++) begin
      @(negedge clk);
      if (!wr && !a_d) begin
        aw_cnt++;
        if (aw_first < 0) aw_first = k;
        if (dato !== a) bad_a++;
      end
      if (!wr && a_d) begin
        dw_cnt++;
        if (dw_first < 0) dw_first = k;
        if (dato !== d) bad_d++;
      end
      if (!rd) begin
        rd_cnt++;
        if (rd_first < 0) rd_first = k;
        if (dato !== rv) bad_r++;
      end
      if (cs && (dato !== 8'h00)) bad_z++;
      if (busy !== (k <= lat)) busy_bad++;
      if (done) begin
        done_cnt++;
        done_k  = k;
        err_s   = err;
        rdata_s = rdata;
      end
      start = pulses && (k == 5 || k == 12);
    end
    start = 1'b0;
    check_val({tag, " addr_wr_first"}, aw_first, 2);
    check_val({tag, " addr_wr_cycles"}, aw_cnt, vfy ? 10 : 5);
    check_val({tag, " addr_bus_bad"}, bad_a, 0);
    check_val({tag, " data_wr_first"}, dw_first, r ? -1 : 16);
    check_val({tag, " data_wr_cycles"}, dw_cnt, r ? 0 : 5);
    check_val({tag, " data_bus_bad"}, bad_d, 0);
    check_val({tag, " rd_first"}, rd_first, r ? 16 : (vfy ? 44 : -1));
    check_val({tag, " rd_cycles"}, rd_cnt, (r || vfy) ? 5 : 0);
    check_val({tag, " rd_bus_bad"}, bad_r, 0);
    check_val({tag, " bus_not_released"}, bad_z, 0);
    check_val({tag, " busy_bad"}, busy_bad, 0);
    check_val({tag, " done_count"}, done_cnt, 1);
    check_val({tag, " done_edge"}, done_k, lat);
  endtask

  logic       e_s;
  logic [7:0] r_s;
  int         dcount;

  initial begin
    // Reset held low for three cycles.
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check_val("rst a_d", a_d, 1'b1);
    check_val("rst cs", cs, 1'b1);
    check_val("rst rd", rd, 1'b1);
    check_val("rst wr", wr, 1'b1);
    check_val("rst busy", busy, 1'b0);
    check_val("rst done", done, 1'b0);
    check_val("rst err", err, 1'b0);
    check_val("rst rdata", rdata, 8'h00);
    check_val("rst dato", dato, 8'h00);

    run_txn("wr21", 1'b0, 8'h21, 8'h45, 8'h45, 1'b0, WLAT, e_s, r_s);
    check_val("wr21 err", e_s, 1'b0);
    check_val("wr21 rdata", r_s, VFY ? 8'h45 : 8'h00);

    run_txn("rd22", 1'b1, 8'h22, 8'hA6, 8'h59, 1'b0, N, e_s, r_s);
    check_val("rd22 rdata", r_s, 8'h59);
    check_val("rd22 err", e_s, 1'b0);

    run_txn("wr30_pulses", 1'b0, 8'h30, 8'h77, 8'h77, 1'b1, WLAT, e_s, r_s);
    check_val("wr30 rdata", r_s, VFY ? 8'h77 : 8'h59);

    // Reset asserted during the read data strobe.
    @(negedge clk);
    rw = 1'b1; addr = 8'h22; wdata = 8'hA6; rdval = 8'h5A; wr_txn = 1'b0; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (17) @(negedge clk);
    check_val("mid rd_low", rd, 1'b0);
    reset = 1'b0;
    @(negedge clk);
    check_val("mid a_d", a_d, 1'b1);
    check_val("mid cs", cs, 1'b1);
    check_val("mid rd", rd, 1'b1);
    check_val("mid wr", wr, 1'b1);
    check_val("mid busy", busy, 1'b0);
    check_val("mid rdata", rdata, 8'h00);
    reset = 1'b1;
    dcount = 0;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      if (done || busy) dcount++;
    end
    check_val("mid no_done", dcount, 0);

    run_txn("rd33", 1'b1, 8'h33, 8'h00, 8'h3C, 1'b0, N, e_s, r_s);
    check_val("rd33 rdata", r_s, 8'h3C);

`ifdef RTC_BUS_WRITE_VERIFY_EN
    run_txn("vfy_ok", 1'b0, 8'h40, 8'h12, 8'h12, 1'b0, WLAT, e_s, r_s);
    check_val("vfy_ok err", e_s, 1'b0);
    check_val("vfy_ok rdata", r_s, 8'h12);
    run_txn("vfy_bad", 1'b0, 8'h40, 8'h12, 8'h13, 1'b0, WLAT, e_s, r_s);
    check_val("vfy_bad err", e_s, 1'b1);
    check_val("vfy_bad rdata", r_s, 8'h13);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
